// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the input sequencer: sequencer state encoding,
// default geometry of the sample buffer, drain lengths and the minimum
// accepted order. Two small helpers decide request validity and the drain
// length for a given order.
// ---------------------------------------------------------------------------
package seq_pkg;

    // Default run geometry
    localparam int NUM_SAMPLES = 20;
    localparam int DATA_W      = 8;

    // Fixed field widths
    localparam int ADDR_W  = 5;
    localparam int N_W     = 3;
    localparam int DRAIN_W = 3;

    // Order handling
    localparam logic [N_W-1:0]     N_MIN       = 3'd2;
    localparam logic [N_W-1:0]     N_SHORT_MAX = 3'd4;
    localparam logic [DRAIN_W-1:0] DRAIN_SHORT = 3'd3;
    localparam logic [DRAIN_W-1:0] DRAIN_LONG  = 3'd7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        SETUP  = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } seq_state_e;

    // An order below N_MIN cannot be computed by the core.
    function automatic logic n_valid(input logic [N_W-1:0] order);
        return (order >= N_MIN);
    endfunction

    // Higher orders keep the core pipeline busy longer after the last sample.
    function automatic logic [DRAIN_W-1:0] drain_load(input logic [N_W-1:0] order);
        logic [DRAIN_W-1:0] cnt;
        if (order <= N_SHORT_MAX) begin
            cnt = DRAIN_SHORT;
        end else begin
            cnt = DRAIN_LONG;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/sample_buffer.sv
// ---------------------------------------------------------------------------
// sample_buffer
// DEPTH x WIDTH sample store with one synchronous write port and one
// combinational read port. The asynchronous reset clears every entry.
//
// Ports
//   clk    : clock, writes on rising edge
//   rst    : asynchronous active-high clear of all entries
//   we     : write strobe (already qualified by the caller)
//   waddr  : write index
//   wdata  : write data
//   raddr  : read index
//   rdata  : read data, combinational from raddr
// ---------------------------------------------------------------------------
module sample_buffer #(
    parameter int DEPTH  = 20,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Storage array: cleared on reset, written on qualified strobes only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (we && (waddr <= LAST_ADDR)) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read port: out-of-range indices read as zero rather than X.
    always_comb begin
        rdata = '0;
        if (raddr <= LAST_ADDR) begin
            rdata = mem_r[raddr];
        end else begin
            rdata = '0;
        end
    end

endmodule

// File: rtl/input_sequencer.sv
// ---------------------------------------------------------------------------
// input_sequencer
// Streams a run of NUM_SAMPLES signed samples from a local buffer into a
// downstream compute core. A run is requested with go in IDLE, announced by
// a one-cycle start pulse, followed by one setup cycle, then samples are
// handed over one per ready-high cycle. After the last sample a fixed drain
// period (length depends on the order n) lets the core finish before done
// pulses. The buffer can only be written while no run is active; any
// rejected write or run request pulses err for one cycle.
//
// Ports
//   clk     : clock, all state changes on rising edge
//   rst     : asynchronous active-high reset
//   wr_en   : buffer write strobe
//   wr_addr : buffer write index
//   wr_data : signed sample to store
//   n_cfg   : order requested for the next run
//   go      : run request, honoured in IDLE only
//   ready   : core accepts X on this edge
//   start   : one-cycle run-start pulse
//   X       : registered signed sample to the core
//   n       : registered order, stable for the whole run
//   busy    : high in every state except IDLE
//   done    : one-cycle pulse at run end
//   err     : one-cycle pulse on a rejected write or run request
// ---------------------------------------------------------------------------
module input_sequencer #(
    parameter int NUM_SAMPLES = seq_pkg::NUM_SAMPLES,
    parameter int DATA_W      = seq_pkg::DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [4:0]               wr_addr,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic [2:0]               n_cfg,
    input  logic                     go,
    input  logic                     ready,
    output logic                     start,
    output logic signed [DATA_W-1:0] X,
    output logic [2:0]               n,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    import seq_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_SAMPLES - 1);

    seq_state_e                state_r;
    logic [ADDR_W-1:0]         idx_r;
    logic [DRAIN_W-1:0]        drain_r;

    logic                      wr_ok_s;
    logic                      wr_bad_s;
    logic                      go_bad_s;
    logic [DATA_W-1:0]         rd_data_s;

    // Request qualification: writes only when idle and in range; a run
    // request is bad when a run is active or the order is too small.
    always_comb begin
        wr_ok_s  = wr_en && (state_r == IDLE) && (wr_addr <= LAST_IDX);
        wr_bad_s = wr_en && !wr_ok_s;
        go_bad_s = go && ((state_r != IDLE) || !n_valid(n_cfg));
    end

    sample_buffer #(
        .DEPTH  (NUM_SAMPLES),
        .WIDTH  (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok_s),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (idx_r),
        .rdata (rd_data_s)
    );

    // Sequencer FSM with its index and drain counters and all outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= '0;
            drain_r <= '0;
            start   <= 1'b0;
            X       <= '0;
            n       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            // Pulses are high for one cycle unless re-armed below.
            start <= 1'b0;
            done  <= 1'b0;
            err   <= wr_bad_s | go_bad_s;

            case (state_r)
                IDLE: begin
                    if (go && n_valid(n_cfg)) begin
                        n       <= n_cfg;
                        start   <= 1'b1;
                        busy    <= 1'b1;
                        state_r <= START;
                    end else begin
                        state_r <= IDLE;
                    end
                end

                START: begin
                    state_r <= SETUP;
                end

                SETUP: begin
                    state_r <= STREAM;
                end

                STREAM: begin
                    if (ready) begin
                        X <= rd_data_s;
                        if (idx_r == LAST_IDX) begin
                            // idx stays on the last entry until DONE clears it.
                            drain_r <= drain_load(n);
                            state_r <= DRAIN;
                        end else begin
                            idx_r <= idx_r + ADDR_W'(1);
                        end
                    end else begin
                        state_r <= STREAM;
                    end
                end

                DRAIN: begin
                    // The edge that takes the count to zero also enters DONE.
                    if (drain_r <= DRAIN_W'(1)) begin
                        drain_r <= '0;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        drain_r <= drain_r - DRAIN_W'(1);
                    end
                end

                DONE: begin
                    idx_r   <= '0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end

                default: begin
                    idx_r   <= '0;
                    drain_r <= '0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_sequencer.sv
// ---------------------------------------------------------------------------
// tb_input_sequencer
// Self-checking bench for input_sequencer: a table of single-cycle IDLE
// vectors for write/request rejection, then full runs whose expected sample
// stream is pushed to a queue at go time from a bench-side buffer model and
// popped as the DUT loads X.
// ---------------------------------------------------------------------------
module tb_input_sequencer;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [4:0]        wr_addr;
    logic signed [7:0] wr_data;
    logic [2:0]        n_cfg;
    logic              go;
    logic              ready;
    logic              start;
    logic signed [7:0] X;
    logic [2:0]        n;
    logic              busy;
    logic              done;
    logic              err;

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [7:0] mem_m [20];
    logic signed [7:0] exp_q [$];
    logic signed [7:0] x_m;

    typedef struct {
        logic       wr_en;
        logic [4:0] wr_addr;
        logic [7:0] wr_data;
        logic       go;
        logic [2:0] n_cfg;
        logic       exp_err;
        logic       exp_start;
        logic       exp_busy;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    input_sequencer #(.NUM_SAMPLES(20), .DATA_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .n_cfg   (n_cfg),
        .go      (go),
        .ready   (ready),
        .start   (start),
        .X       (X),
        .n       (n),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    task automatic chk(input string nm, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_buf(input int base, input int step);
        for (int i = 0; i < 20; i++) begin
            wr_en   = 1'b1;
            wr_addr = 5'(i);
            wr_data = 8'(base + step * i);
            tick();
            chk("wr_no_err", err, 1'b0);
            mem_m[i] = 8'(base + step * i);
        end
        wr_en = 1'b0;
    endtask

    // mode 0: ready always high, 1: ready toggles 1/0, 2: random ready.
    task automatic do_run(input logic [2:0] ncfg, input int mode, input int inject_at,
                          input int abort_at, input bit wr_same,
                          input logic [4:0] wa, input logic signed [7:0] wd);
        int                loads;
        int                cyc;
        int                d;
        logic              r;
        bit                injected;
        bit                inj_now;
        logic signed [7:0] e;

        injected = 1'b0;
        inj_now  = 1'b0;
        exp_q.delete();
        go    = 1'b1;
        n_cfg = ncfg;
        ready = 1'b1;
        if (wr_same) begin
            wr_en   = 1'b1;
            wr_addr = wa;
            wr_data = wd;
            mem_m[wa] = wd;
        end
        for (int i = 0; i < 20; i++) exp_q.push_back(mem_m[i]);

        tick();
        go    = 1'b0;
        wr_en = 1'b0;
        n_cfg = 3'd0;
        chk("start_pulse", start, 1'b1);
        chk("busy_start", busy, 1'b1);
        chk("n_latched", n, ncfg);
        chk("err_go_ok", err, 1'b0);
        tick();
        chk("start_cleared", start, 1'b0);
        chk("n_setup", n, ncfg);
        chk("x_hold_setup", X, x_m);
        tick();
        chk("x_hold_pre_stream", X, x_m);

        loads = 0;
        cyc   = 0;
        while (loads < 20 && cyc < 200) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 2 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            ready = r;
            if (!injected && loads == inject_at) begin
                wr_en    = 1'b1;
                wr_addr  = 5'd3;
                wr_data  = 8'sh55;
                go       = 1'b1;
                n_cfg    = 3'd2;
                injected = 1'b1;
                inj_now  = 1'b1;
            end
            tick();
            cyc++;
            if (inj_now) begin
                chk("err_busy_req", err, 1'b1);
                chk("no_restart", start, 1'b0);
                wr_en   = 1'b0;
                go      = 1'b0;
                inj_now = 1'b0;
            end
            if (r) begin
                e = exp_q.pop_front();
                chk("x_load", X, e);
                x_m = e;
                loads++;
            end else begin
                chk("x_hold_stream", X, x_m);
            end
            chk("n_stable", n, ncfg);
            if (loads == abort_at) begin
                #2 rst = 1'b1;
                #1;
                x_m = 8'sd0;
                for (int i = 0; i < 20; i++) mem_m[i] = 8'sd0;
                exp_q.delete();
                chk("rst_x", X, x_m);
                chk("rst_start", start, 1'b0);
                chk("rst_busy", busy, 1'b0);
                chk("rst_done", done, 1'b0);
                chk("rst_err", err, 1'b0);
                chk("rst_n", n, 3'd0);
                @(negedge clk);
                rst = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    tick();
                    chk("no_done_after_abort", done, 1'b0);
                    chk("idle_after_abort", busy, 1'b0);
                end
                return;
            end
        end
        if (loads < 20) chk("stream_timeout", loads, 20);

        d = (ncfg <= 3'd4) ? 3 : 7;
        for (int k = 1; k <= d; k++) begin
            ready = 1'($urandom_range(0, 1));
            tick();
            chk("done_timing", done, (k == d));
            chk("x_drain_hold", X, x_m);
        end
        ready = 1'b0;
        tick();
        chk("done_clear", done, 1'b0);
        chk("busy_clear", busy, 1'b0);
        chk("n_after_run", n, ncfg);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 5'd20, 8'd77,  1'b0, 3'd0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 5'd31, 8'hFF,  1'b0, 3'd0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 5'd0,  8'd0,   1'b1, 3'd1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 5'd0,  8'd0,   1'b1, 3'd0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 5'd0,  8'd0,   1'b0, 3'd5, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 5'd19, 8'd9,   1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 5'd20, 8'd1,   1'b1, 3'd1, 1'b1, 1'b0, 1'b0};

        rst     = 1'b0;
        wr_en   = 1'b0;
        wr_addr = 5'd0;
        wr_data = 8'sd0;
        n_cfg   = 3'd0;
        go      = 1'b0;
        ready   = 1'b0;
        x_m     = 8'sd0;
        for (int i = 0; i < 20; i++) mem_m[i] = 8'sd0;

        #2 rst = 1'b1;
        #1;
        chk("reset_x", X, x_m);
        chk("reset_n", n, 3'd0);
        chk("reset_start", start, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_err", err, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        load_buf(-10, 1);

        for (int v = 0; v < 7; v++) begin
            wr_en   = vecs[v].wr_en;
            wr_addr = vecs[v].wr_addr;
            wr_data = vecs[v].wr_data;
            go      = vecs[v].go;
            n_cfg   = vecs[v].n_cfg;
            tick();
            wr_en = 1'b0;
            go    = 1'b0;
            if (vecs[v].wr_en && vecs[v].wr_addr < 5'd20) mem_m[vecs[v].wr_addr] = vecs[v].wr_data;
            chk("vec_err", err, vecs[v].exp_err);
            chk("vec_start", start, vecs[v].exp_start);
            chk("vec_busy", busy, vecs[v].exp_busy);
            chk("vec_n_unchanged", n, 3'd0);
        end
        tick();
        chk("err_one_cycle", err, 1'b0);

        do_run(3'd2, 0, -1, -1, 1'b0, 5'd0, 8'sd0);
        do_run(3'd7, 1, 6, -1, 1'b0, 5'd0, 8'sd0);
        do_run(3'd4, 2, -1, -1, 1'b1, 5'd7, 8'sd100);
        do_run(3'd5, 0, -1, 10, 1'b0, 5'd0, 8'sd0);
        load_buf(-50, 5);
        do_run(3'd3, 2, -1, -1, 1'b0, 5'd0, 8'sd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/input_sequencer.md
INPUT_SEQUENCER -- requirements
Module: input_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_SAMPLES, default 20, meaning the number of samples per run.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning the signed sample width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-005 The block SHALL have port wr_en, input, 1, the buffer write strobe.
REQ-006 The block SHALL have port wr_addr, input, 5, the buffer write index.
REQ-007 The block SHALL have port wr_data, input, DATA_W, the signed sample to store.
REQ-008 The block SHALL have port n_cfg, input, 3, the requested order for the next run.
REQ-009 The block SHALL have port go, input, 1, a run request sampled in IDLE only.
REQ-010 The block SHALL have port ready, input, 1, from the downstream compute core; high means it accepts X.
REQ-011 The block SHALL have port start, output, 1, a one-cycle run-start pulse to the core.
REQ-012 The block SHALL have port X, output, DATA_W, the registered signed sample to the core.
REQ-013 The block SHALL have port n, output, 3, the registered order, stable for the whole run.
REQ-014 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 The block SHALL have port done, output, 1, a one-cycle pulse at run end.
REQ-016 The block SHALL have port err, output, 1, a one-cycle pulse on a rejected request.

Function
REQ-017 The FSM SHALL have states IDLE, START, SETUP, STREAM, DRAIN and DONE.
REQ-018 IDLE: go=1 with 2<=n_cfg<=7 SHALL latch n_cfg into n and move to START on the next edge.
REQ-019 IDLE: go=1 with n_cfg<2 SHALL pulse err for one cycle and remain in IDLE, with n unchanged.
REQ-020 START SHALL assert start for exactly one cycle, then go to SETUP.
REQ-021 SETUP SHALL last exactly one cycle with start=0 and n stable, then go to STREAM.
REQ-022 STREAM, on an edge with ready=1, SHALL load X with buf[idx] and increment idx (0..NUM_SAMPLES-1).
REQ-023 STREAM, on an edge with ready=0, SHALL hold X and idx.
REQ-024 The edge that loads the sample at idx=NUM_SAMPLES-1 SHALL move to DRAIN and load the drain counter: 3 if n<=4, else 7.
REQ-025 DRAIN SHALL decrement once per cycle, ignore ready, and move to DONE when the count reaches 0.
REQ-026 DONE SHALL pulse done for one cycle and return to IDLE, with idx cleared to 0.
REQ-027 X SHALL hold its last value outside STREAM.
REQ-028 A buffer write SHALL occur when wr_en=1, busy=0 and wr_addr<NUM_SAMPLES.
REQ-029 Any other wr_en=1 SHALL be dropped and pulse err.
REQ-030 go=1 while busy SHALL be ignored and pulse err.
REQ-031 When go and a valid wr_en occur in the same IDLE cycle, the write SHALL complete and the run SHALL start.
REQ-032 Total run length from go edge to done SHALL be 3 + (ready-high cycles needed for 20 samples) + drain count + 1 cycles.

Reset
REQ-033 rst=1 SHALL immediately force IDLE, start=0, X=0, n=0, busy=0, done=0, err=0, idx=0, drain counter=0 and all buffer entries=0.
REQ-034 rst asserted mid-run SHALL abort the run with no done pulse.
REQ-035 After rst is released, the first edge SHALL be handled as IDLE.

Structure
REQ-036 Package seq_pkg SHALL hold the state enum, NUM_SAMPLES, DATA_W, DRAIN_SHORT=3, DRAIN_LONG=7 and N_MIN=2.
REQ-037 The buffer SHALL be sub-module sample_buffer: NUM_SAMPLES x DATA_W, 1 synchronous write port, 1 combinational read port, asynchronous clear.
REQ-038 The FSM, idx counter and drain counter SHALL reside in input_sequencer.

Verification
REQ-039 Load buf[i]=i-10 for i=0..19, n_cfg=2, go, ready held high -> start at cycle 1; X=-10..9 on consecutive cycles; done 3 cycles after X=9.
REQ-040 n_cfg=7 with ready toggling 1/0 -> each sample held 2 cycles; done 7 cycles after the last load; n=7 throughout.
REQ-041 n_cfg=1, go -> err pulse; busy stays 0; no start.
REQ-042 During STREAM: wr_en=1, wr_addr=3, and go=1 -> err pulses; buf[3] unchanged on a later run.
REQ-043 rst pulse at idx=10 -> all outputs 0 at once; no done; a fresh go replays from buf[0].
REQ-044 wr_addr=20 in IDLE -> err pulse; no buffer change.
